// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin merge of two queued register-file write streams into one write port
module rf_wr_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_addr,
    input  logic [31:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_addr,
    input  logic [31:0] i_b_data,
    output logic        o_b_ready,
    output logic        o_we,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata,
    output logic [31:0] o_pend
);
    localparam int AW = $clog2(DEPTH);
    logic [4:0]  q_addr [2][DEPTH];
    logic [31:0] q_data [2][DEPTH];
    logic [AW:0] wr_ptr [2];
    logic [AW:0] rd_ptr [2];
    logic [4:0]  addr_in [2];
    logic [31:0] data_in [2];
    logic [1:0]  valid_in, full, empty, push, pop;
    logic        last_b;
    logic [4:0]  g_addr;
    logic [31:0] g_data;
    always_comb begin
        valid_in = {i_b_valid, i_a_valid};
        addr_in[0] = i_a_addr;
        addr_in[1] = i_b_addr;
        data_in[0] = i_a_data;
        data_in[1] = i_b_data;
        for (int q = 0; q < 2; q++) begin
            empty[q] = wr_ptr[q] == rd_ptr[q];
            full[q] = (wr_ptr[q][AW] != rd_ptr[q][AW]) && (wr_ptr[q][AW-1:0] == rd_ptr[q][AW-1:0]);
        end
        o_a_ready = !full[0] && !i_rst;
        o_b_ready = !full[1] && !i_rst;
        push = valid_in & {o_b_ready, o_a_ready};
        pop[0] = !empty[0] && (empty[1] || last_b);
        pop[1] = !empty[1] && (empty[0] || !last_b);
        g_addr = pop[1] ? q_addr[1][rd_ptr[1][AW-1:0]] : q_addr[0][rd_ptr[0][AW-1:0]];
        g_data = pop[1] ? q_data[1][rd_ptr[1][AW-1:0]] : q_data[0][rd_ptr[0][AW-1:0]];
    end
    always_ff @(posedge i_clk) begin
        for (int q = 0; q < 2; q++) begin
            if (push[q]) begin
                q_addr[q][wr_ptr[q][AW-1:0]] <= addr_in[q];
                q_data[q][wr_ptr[q][AW-1:0]] <= data_in[q];
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int q = 0; q < 2; q++) begin
                wr_ptr[q] <= '0;
                rd_ptr[q] <= '0;
            end
            last_b <= 1'b1;
            o_we <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                wr_ptr[q] <= wr_ptr[q] + (AW+1)'(push[q]);
                rd_ptr[q] <= rd_ptr[q] + (AW+1)'(pop[q]);
            end
            if (|pop) last_b <= pop[1];
            o_we <= |pop && g_addr != 5'd0;
            o_waddr <= g_addr;
            o_wdata <= g_data;
        end
    end
    always_comb begin
        o_pend = '0;
        for (int q = 0; q < 2; q++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((AW+1)'(k) < wr_ptr[q] - rd_ptr[q])
                    o_pend = o_pend | (32'd1 << q_addr[q][rd_ptr[q][AW-1:0] + AW'(k)]);
            end
        end
        if (o_we) o_pend = o_pend | (32'd1 << o_waddr);
        o_pend[0] = 1'b0;
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: queue-based reference model compared against the arbiter every cycle
module tb_rf_wr_arbiter;
    localparam int DEPTH = 2;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_a_valid = 1'b0;
    logic [4:0]  i_a_addr = '0;
    logic [31:0] i_a_data = '0;
    logic        o_a_ready;
    logic        i_b_valid = 1'b0;
    logic [4:0]  i_b_addr = '0;
    logic [31:0] i_b_data = '0;
    logic        o_b_ready;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [31:0] o_pend;
    int checks = 0;
    int failures = 0;
    logic [36:0] qa[$];
    logic [36:0] qb[$];
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        last_b;
    logic        after_rst;
    always #5 i_clk = ~i_clk;
    rf_wr_arbiter #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_valid(i_a_valid), .i_a_addr(i_a_addr), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_addr(i_b_addr), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_pend(o_pend)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] model_pend();
        logic [31:0] p = '0;
        foreach (qa[i]) p[qa[i][36:32]] = 1'b1;
        foreach (qb[i]) p[qb[i][36:32]] = 1'b1;
        if (exp_we) p[exp_waddr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction
    task automatic cycle(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        logic acc_a, acc_b, ga, gb;
        logic [36:0] e;
        i_rst = rst;
        i_a_valid = av;
        i_a_addr = aa;
        i_a_data = ad;
        i_b_valid = bv;
        i_b_addr = ba;
        i_b_data = bd;
        @(negedge i_clk);
        check("a_ready", 32'(o_a_ready), 32'(!rst && qa.size() < DEPTH));
        check("b_ready", 32'(o_b_ready), 32'(!rst && qb.size() < DEPTH));
        check("we", 32'(o_we), 32'(exp_we));
        if (exp_we) begin
            check("waddr", 32'(o_waddr), 32'(exp_waddr));
            check("wdata", o_wdata, exp_wdata);
        end
        if (after_rst) begin
            check("rst_waddr", 32'(o_waddr), 32'd0);
            check("rst_wdata", o_wdata, 32'd0);
        end
        check("pend", o_pend, model_pend());
        acc_a = !rst && av && qa.size() < DEPTH;
        acc_b = !rst && bv && qb.size() < DEPTH;
        if (rst) begin
            qa.delete();
            qb.delete();
            exp_we = 1'b0;
            exp_waddr = '0;
            exp_wdata = '0;
            last_b = 1'b1;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            ga = qa.size() > 0 && (qb.size() == 0 || last_b);
            gb = !ga && qb.size() > 0;
            exp_we = 1'b0;
            if (ga || gb) begin
                if (ga) e = qa.pop_front();
                else e = qb.pop_front();
                last_b = gb;
                exp_we = e[36:32] != 5'd0;
                exp_waddr = e[36:32];
                exp_wdata = e[31:0];
            end
            if (acc_a) qa.push_back({aa, ad});
            if (acc_b) qb.push_back({ba, bd});
        end
        @(posedge i_clk);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask
    initial begin
        @(posedge i_clk);
        #1;
        exp_we = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        last_b = 1'b1;
        after_rst = 1'b1;
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(1);
        cycle(1'b0, 1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(3);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 1'b1, 5'd3, 32'hABBABAAB, 1'b1, 5'd5, 32'h12345678);
        idle(3);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 5'(i + 8), $urandom, 1'b1, 5'(i + 20), $urandom);
        idle(4);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 2), 32'h1000 + 32'(i));
        idle(3);
        cycle(1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(3);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 5'd7, $urandom, 1'b1, 5'd9, $urandom);
        cycle(1'b1, 1'b1, 5'd11, 32'hBAD0BAD0, 1'b1, 5'd12, 32'hBAD1BAD1);
        idle(3);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entries per requester queue (power of 2, >=2).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_a_valid  input  1  requester A (ALU writeback) write request.
REQ-005 SHALL have port i_a_addr  input  5  requester A destination register.
REQ-006 SHALL have port i_a_data  input  32  requester A write data.
REQ-007 SHALL have port o_a_ready  output  1  queue A can accept.
REQ-008 SHALL have port i_b_valid  input  1  requester B (load/mul-div unit) write request.
REQ-009 SHALL have port i_b_addr  input  5  requester B destination register.
REQ-010 SHALL have port i_b_data  input  32  requester B write data.
REQ-011 SHALL have port o_b_ready  output  1  queue B can accept.
REQ-012 SHALL have port o_we  output  1  register-file write enable.
REQ-013 SHALL have port o_waddr  output  5  register-file write address.
REQ-014 SHALL have port o_wdata  output  32  register-file write data.
REQ-015 SHALL have port o_pend  output  32  bit n set while a write to register n is queued or on the output.

Function
REQ-016 SHALL accept a request on a requester when valid and ready are both high at a rising edge, pushing {addr,data} into that requester's FIFO.
REQ-017 SHALL drive o_x_ready = queue not full, registered-state only (no combinational dependency on i_x_valid); no push when full, even if a pop happens that cycle.
REQ-018 SHALL, each cycle, arbitrate between non-empty queue heads and pop at most one entry into the output register at the next edge.
REQ-019 SHALL use round-robin: one head valid -> grant it; both valid -> grant requester not granted last; last-grant pointer updates on every grant.
REQ-020 SHALL load output register {o_we,o_waddr,o_wdata} every edge: o_we=1 with granted entry if a grant occurred and addr!=0, else o_we=0.
REQ-021 SHALL consume entries targeting register 0 (popped, granted, pointer updated) without ever asserting o_we for them.
REQ-022 SHALL give minimum latency: accepted at edge k -> o_we high in cycle after edge k+1 -> register file written at edge k+2.
REQ-023 SHALL preserve order within a requester; cross-requester order follows grant order only.
REQ-024 SHALL sustain one write per cycle when either queue is non-empty; a lone active requester SHALL never be blocked by the pointer.
REQ-025 SHALL compute o_pend combinationally as OR over all valid queue entries and the output register (when o_we=1) of one-hot(addr); bit 0 always 0.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH; full/empty distinguished by an extra pointer bit or count.
REQ-027 SHALL allow simultaneous push and pop on the same queue (non-full) with count unchanged.

Reset
REQ-028 SHALL, on i_rst high at an edge, empty both queues, set o_we=0, o_waddr=0, o_wdata=0, last-grant pointer = B (A wins first tie).
REQ-029 SHALL hold o_a_ready=o_b_ready=0 while i_rst is high and set both to 1 in the first cycle after reset.
REQ-030 SHALL, on reset mid-operation, discard all queued and in-flight writes; no o_we pulse in the cycle after the reset edge.

Verification
REQ-031 SHALL pass: single A write addr=1 data=DEADBEEF -> o_we=1, o_waddr=1, o_wdata=DEADBEEF exactly one cycle after acceptance edge; o_pend[1]=1 from acceptance until that o_we cycle ends.
REQ-032 SHALL pass: A (addr 3, ABBABAAB) and B (addr 5, 12345678) accepted same edge after reset -> A written first, B next cycle, no idle cycle.
REQ-033 SHALL pass: A and B continuously valid for 8 cycles -> grants alternate A,B,A,B...; each requester 4 writes, in-order per requester.
REQ-034 SHALL pass: B alone pushes DEPTH+1 requests with no pop opportunity blocked -> o_b_ready drops only if FIFO reaches full; all values written in order, none lost/duplicated.
REQ-035 SHALL pass: A write addr=0 data=DEADBEEF -> o_a_ready behaves normally, o_we never asserted, o_pend stays 0.
REQ-036 SHALL pass: fill both queues, assert i_rst one cycle -> next cycle o_we=0, o_pend=0, both ready=1; no stale data ever written.
